// File: rtl/burst_capture_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_capture_gate_pkg: shared FSM states and width helpers          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package burst_capture_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam int TSTAMP_W = 64;

  function automatic int calc_cw(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_capture_gate_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_out_reg: 1-deep AXI hold register carrying {tlast, I, Q}        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module burst_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_idata,
  input  logic [DATA_WIDTH-1:0] load_qdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic [DATA_WIDTH-1:0] out_itdata,
  output logic [DATA_WIDTH-1:0] out_qtdata
);

  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_idata;
  logic [DATA_WIDTH-1:0] r_qdata;

  // Caller only loads when the register is empty or draining this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idata <= '0;
      r_qdata <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_last  <= load_last;
      r_idata <= load_idata;
      r_qdata <= load_qdata;
    end else if (out_tready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign out_tvalid = r_valid;
  assign out_tlast  = r_last;
  assign out_itdata = r_idata;
  assign out_qtdata = r_qdata;

endmodule
`default_nettype wire

// File: rtl/burst_capture_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_capture_gate: trigger-gated burst capture of an IQ AXI stream   |
// | Option BURST_CAPTURE_TSTAMP_EN adds out_tstamp.          Rev 1.0     |
// +----------------------------------------------------------------------+
module burst_capture_gate
  import burst_capture_gate_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int MAX_LEN     = 4095,
  parameter  int DEF_OFFSET  = 0,
  parameter  int DEF_LEN     = 1024,
  parameter  int DEF_HOLDOFF = 256,
  localparam int CW          = calc_cw(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  cfg_stb,
  input  logic [CW-1:0]         cfg_offset,
  input  logic [CW-1:0]         cfg_len,
  input  logic [CW-1:0]         cfg_holdoff,
  input  logic                  peak_stb,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic [DATA_WIDTH-1:0] in_itdata,
  input  logic [DATA_WIDTH-1:0] in_qtdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic [DATA_WIDTH-1:0] out_itdata,
  output logic [DATA_WIDTH-1:0] out_qtdata,
`ifdef BURST_CAPTURE_TSTAMP_EN
  output logic [TSTAMP_W-1:0]   out_tstamp,
`endif
  output logic                  busy,
  output logic                  trig_miss
);

  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_offset;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_holdoff;
  logic          r_peak_d;
  logic          r_trig_miss;

  logic          w_trig;
  logic          w_idle;
  logic          w_cfg_ld;
  logic [CW-1:0] w_offset_now;
  logic [CW-1:0] w_len_now;
  logic [CW-1:0] w_len_now_eff;
  logic [CW-1:0] w_len_reg_eff;
  logic          w_beat;
  logic          w_cnt_last;
  logic          w_load;
  logic          w_flush;
  logic          w_unused;

  assign w_unused = in_tlast;  // framing comes from the counter alone

  assign w_trig   = peak_stb & ~r_peak_d;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_cfg_ld = cfg_stb & w_idle;

  // A config strobe coinciding with the trigger governs that same burst.
  assign w_offset_now  = w_cfg_ld ? cfg_offset : r_offset;
  assign w_len_now     = w_cfg_ld ? cfg_len : r_len;
  assign w_len_now_eff = (w_len_now == '0) ? c_cnt_one : w_len_now;
  assign w_len_reg_eff = (r_len == '0) ? c_cnt_one : r_len;

  assign in_tready  = (r_state == ST_CAPTURE) ? (~out_tvalid | out_tready) : 1'b1;
  assign w_beat     = in_tvalid & in_tready;
  assign w_cnt_last = (r_cnt == c_cnt_one);
  assign w_load     = w_beat & (r_state == ST_CAPTURE) & ~clear;
  assign w_flush    = clear & (r_state == ST_CAPTURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_offset    <= CW'(DEF_OFFSET);
      r_len       <= CW'(DEF_LEN);
      r_holdoff   <= CW'(DEF_HOLDOFF);
      r_peak_d    <= 1'b0;
      r_trig_miss <= 1'b0;
    end else begin
      r_peak_d    <= peak_stb;
      r_trig_miss <= w_trig & ~w_idle;
      if (w_cfg_ld) begin
        r_offset  <= cfg_offset;
        r_len     <= cfg_len;
        r_holdoff <= cfg_holdoff;
      end
      if (clear) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_trig) begin
              if (w_offset_now == '0) begin
                r_state <= ST_CAPTURE;
                r_cnt   <= w_len_now_eff;
              end else begin
                r_state <= ST_SKIP;
                r_cnt   <= w_offset_now;
              end
            end
          end
          ST_SKIP: begin
            if (w_beat) begin
              if (w_cnt_last) begin
                r_state <= ST_CAPTURE;
                r_cnt   <= w_len_reg_eff;
              end else begin
                r_cnt <= r_cnt - c_cnt_one;
              end
            end
          end
          ST_CAPTURE: begin
            // Last word may still sit in the output register after we leave.
            if (w_beat) begin
              if (w_cnt_last) begin
                if (r_holdoff == '0) begin
                  r_state <= ST_IDLE;
                end else begin
                  r_state <= ST_HOLDOFF;
                  r_cnt   <= r_holdoff;
                end
              end else begin
                r_cnt <= r_cnt - c_cnt_one;
              end
            end
          end
          ST_HOLDOFF: begin
            if (w_beat) begin
              if (w_cnt_last) begin
                r_state <= ST_IDLE;
              end else begin
                r_cnt <= r_cnt - c_cnt_one;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = ~w_idle;
  assign trig_miss = r_trig_miss;

  burst_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (w_flush),
    .load       (w_load),
    .load_last  (w_cnt_last),
    .load_idata (in_itdata),
    .load_qdata (in_qtdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .out_itdata (out_itdata),
    .out_qtdata (out_qtdata)
  );

`ifdef BURST_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] r_sample_cnt;
  logic [TSTAMP_W-1:0] r_tstamp;

  // Latched on the first captured beat only (counter still at its full length).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_cnt <= '0;
      r_tstamp     <= '0;
    end else begin
      if (w_beat) r_sample_cnt <= r_sample_cnt + TSTAMP_W'(1);
      if (w_load && (r_cnt == w_len_reg_eff)) r_tstamp <= r_sample_cnt;
    end
  end

  assign out_tstamp = r_tstamp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_burst_capture_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_burst_capture_gate: table-driven + random bench for the gate       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_burst_capture_gate;

  localparam int DW = 16;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          cfg_stb = 1'b0;
  logic [CW-1:0] cfg_offset = '0;
  logic [CW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_holdoff = '0;
  logic          peak_stb = 1'b0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] in_itdata = '0;
  logic [DW-1:0] in_qtdata = '0;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic [DW-1:0] out_itdata;
  logic [DW-1:0] out_qtdata;
  logic          busy;
  logic          trig_miss;
`ifdef BURST_CAPTURE_TSTAMP_EN
  logic [63:0]   out_tstamp;
  logic [63:0]   got_ts[$];
`endif

  burst_capture_gate #(.DATA_WIDTH(DW), .MAX_LEN(4095)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cfg_stb(cfg_stb),
    .cfg_offset(cfg_offset), .cfg_len(cfg_len), .cfg_holdoff(cfg_holdoff),
    .peak_stb(peak_stb), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_tlast(in_tlast), .in_itdata(in_itdata), .in_qtdata(in_qtdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_itdata(out_itdata), .out_qtdata(out_qtdata),
`ifdef BURST_CAPTURE_TSTAMP_EN
    .out_tstamp(out_tstamp),
`endif
    .busy(busy), .trig_miss(trig_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int offset; int len; int holdoff;
    bit cfg_with_trig; bit trig_on_beat;
    int rdy_pct; int vld_pct;
    int exp_first; int exp_words;
  } row_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_ts = -1;
  bit          s_beat;
  logic [DW-1:0] got_d[$];
  logic [DW-1:0] got_q[$];
  logic        got_l[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then sample away from the rising edge.
  task automatic cyc(input bit vld, input int val, input bit pk, input bit rdy,
                     input bit cs, input bit clr);
    @(negedge clk);
    in_tvalid  = vld;
    in_itdata  = DW'(val);
    in_qtdata  = DW'(val) ^ 16'h5A5A;
    in_tlast   = vld & ($urandom_range(7) == 0);
    peak_stb   = pk;
    out_tready = rdy;
    cfg_stb    = cs;
    clear      = clr;
    #1;
    s_beat = in_tvalid & in_tready;
    if (out_tvalid && out_tready) begin
      got_d.push_back(out_itdata);
      got_q.push_back(out_qtdata);
      got_l.push_back(out_tlast);
`ifdef BURST_CAPTURE_TSTAMP_EN
      got_ts.push_back(out_tstamp);
`endif
    end
  endtask

  task automatic clear_got();
    got_d.delete(); got_q.delete(); got_l.delete();
`ifdef BURST_CAPTURE_TSTAMP_EN
    got_ts.delete();
`endif
  endtask

  // Reference: after the trigger cycle, drop `offset` beats, capture `len` (min 1)
  // consecutive ramp values, last one flagged; nothing else may appear.
  task automatic run_burst(input row_t r);
    int val = 0;
    int beats = 0;
    int n = 0;
    int n0;
    bit vld, rdy;
    cfg_offset  = CW'(r.offset);
    cfg_len     = CW'(r.len);
    cfg_holdoff = CW'(r.holdoff);
    if (!r.cfg_with_trig) cyc(0, 0, 0, 1, 1, 0);
    clear_got();
    cyc(r.trig_on_beat, val, 1, 1, r.cfg_with_trig, 0);
    if (s_beat) val++;
    while (!(got_d.size() >= r.exp_words && !busy) && n < 4000) begin
      vld = ($urandom_range(99) < r.vld_pct);
      rdy = ($urandom_range(99) < r.rdy_pct);
      cyc(vld, val, 0, rdy, 0, 0);
      if (beats >= r.offset && beats < r.offset + r.exp_words && out_tvalid && !rdy)
        check("held_no_ready", 64'(in_tready), 64'd0);
      if (s_beat) begin
        val++;
        beats++;
      end
      n++;
    end
    check("burst_done_in_time", 64'(n < 4000), 64'd1);
    check("word_count", 64'(got_d.size()), 64'(r.exp_words));
    for (int i = 0; i < got_d.size() && i < r.exp_words; i++) begin
      check($sformatf("word%0d_i", i), 64'(got_d[i]), 64'(DW'(r.exp_first + i)));
      check($sformatf("word%0d_q", i), 64'(got_q[i]), 64'(DW'(r.exp_first + i) ^ 16'h5A5A));
      check($sformatf("word%0d_last", i), 64'(got_l[i]), 64'(i == r.exp_words - 1));
`ifdef BURST_CAPTURE_TSTAMP_EN
      if (exp_ts >= 0) check($sformatf("tstamp%0d", i), got_ts[i], 64'(exp_ts));
`endif
    end
    n0 = got_d.size();
    for (int i = 0; i < 20; i++) cyc(1, val + i, 0, 1, 0, 0);
    check("no_extra_words", 64'(got_d.size()), 64'(n0));
  endtask

  row_t rows[7];
  row_t row_full;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            off len ho  cwt tob rdy vld first words
    rows[0] = '{0,  4,  0,  0,  1, 100, 100, 1,  4};
    rows[1] = '{3,  2,  0,  0,  0, 100, 100, 3,  2};
    rows[2] = '{0,  8,  0,  0,  0, 50,  60,  0,  8};
    rows[3] = '{5,  8,  3,  1,  0, 50,  70,  5,  8};
    rows[4] = '{2,  0,  1,  0,  1, 70,  80,  3,  1};
    rows[5] = '{1,  1,  2,  1,  1, 60,  50,  2,  1};
    rows[6] = '{7,  16, 10, 0,  0, 50,  50,  7,  16};
    row_full = '{0, 6, 0, 0, 0, 100, 100, 0, 6};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_out_tlast", 64'(out_tlast), 64'd0);
    check("rst_out_data", 64'({out_itdata, out_qtdata}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_trig_miss", 64'(trig_miss), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    // Default offset 0: first beat after the trigger is captured; clear discards it.
    clear_got();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 'h11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("dflt_captured_valid", 64'(out_tvalid), 64'd1);
    check("dflt_captured_data", 64'(out_itdata), 64'h11);
    check("dflt_busy", 64'(busy), 64'd1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("clear_drops_word", 64'(out_tvalid), 64'd0);
    check("clear_idle", 64'(busy), 64'd0);
    check("clear_no_xfer", 64'(got_d.size()), 64'd0);

    for (int r = 0; r < 7; r++) run_burst(rows[r]);

    // Triggers during CAPTURE and HOLDOFF are reported and ignored.
    cfg_offset = '0; cfg_len = CW'(3); cfg_holdoff = CW'(5);
    cyc(0, 0, 0, 1, 1, 0);
    clear_got();
    cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 2, 1, 1, 0, 0);
    check("miss_in_capture", 64'(trig_miss), 64'd1);
    cyc(1, 3, 0, 1, 0, 0);
    check("miss_pulse_one_cycle", 64'(trig_miss), 64'd0);
    cyc(1, 4, 1, 1, 0, 0);
    cyc(1, 5, 0, 1, 0, 0);
    check("miss_in_holdoff", 64'(trig_miss), 64'd1);
    cyc(1, 6, 0, 1, 0, 0);
    cyc(1, 7, 0, 1, 0, 0);
    check("busy_last_holdoff_beat", 64'(busy), 64'd1);
    cyc(0, 8, 0, 1, 0, 0);
    check("idle_after_holdoff", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) cyc(1, 9 + i, 0, 1, 0, 0);
    check("miss_burst_words", 64'(got_d.size()), 64'd3);
    if (got_d.size() == 3) begin
      check("miss_burst_data", 64'({got_d[0], got_d[1], got_d[2]}), {16'd0, 16'd0, 16'd1, 16'd2});
      check("miss_burst_last", 64'({got_l[0], got_l[1], got_l[2]}), 64'b001);
    end

    // Asynchronous reset with a word held and 3 words still to capture.
    cfg_offset = '0; cfg_len = CW'(6); cfg_holdoff = '0;
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, i, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("held_before_reset", 64'(out_tvalid), 64'd1);
    reset = 1'b0;
    #1;
    check("areset_out_tvalid", 64'(out_tvalid), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_tlast", 64'(out_tlast), 64'd0);
    @(negedge clk);
    in_tvalid = 1'b0; out_tready = 1'b1;
    reset = 1'b1;
    run_burst(row_full);

`ifdef BURST_CAPTURE_TSTAMP_EN
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1, i, 0, 1, 0, 0);
    exp_ts = 102;
    run_burst('{2, 4, 0, 0, 0, 100, 100, 2, 4});
    exp_ts = -1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
